bvlshr_inv_search_solver: RTL and testbench
===========================================

// Module: bvlshr_inv_search_solver
// PURPOSE
//  Parametrised, sequential successor to the 4-bit combinational Skolem blocks for
//  bvsgt/bvlshr. Given s and t of WIDTH bits and a predicate op, it finds a shift
//  amount x such that (s >>u x) op t holds (x is operand 1 of bvlshr).
//  The search is a bounded linear scan, one candidate per clock. Handshakes are
//  valid/ready on the input and output sides. The block sits in the invertibility
//  checking datapath; its x/found feed the witness checker.
// PARAMETERS
//  WIDTH   4   bit width of s, t and x. Legal range is WIDTH >= 2.
//  KW      $clog2(WIDTH+1)   width of the candidate counter. Derived; do not override.
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request
//  s          in   WIDTH  value to be shifted
//  t          in   WIDTH  comparison operand
//  op         in   2      predicate: 00 sgt, 01 ugt, 10 slt, 11 ult
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts the result
//  x          out  WIDTH  witness shift amount. 0 when found = 0.
//  found      out  1      1 = x satisfies the predicate; 0 = no x exists
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge)
//    - State goes to IDLE; the request is abandoned even mid-search.
//    - Reset values: in_ready = 0 during reset and 1 after it; out_valid = 0,
//      x = 0, found = 0.
//  - Search range
//    - Candidates are k = 0..WIDTH.
//    - Any shift >= WIDTH gives the same result (0) as k = WIDTH, so the range
//      is exhaustive.
//    - k = WIDTH fits in WIDTH bits because WIDTH >= 2.
//  - Evaluation, each SEARCH cycle
//    - r = s_q >> k, logical shift with zero fill.
//    - Compare r against t_q: signed (two's complement) when op[0] = 0, unsigned
//      when op[0] = 1.
//    - op[1] = 0 tests greater-than; op[1] = 1 tests less-than. Both are strict.
//  - FSM states
//    - IDLE: in_ready = 1. On in_valid & in_ready, capture s, t, op into
//      s_q, t_q, op_q, set k = 0, go to SEARCH. Inputs are not sampled in any
//      other state.
//    - SEARCH: in_ready = 0.
//      - Hit at k: x <= k (zero-extended), found <= 1, go to DONE.
//      - Miss with k == WIDTH: x <= 0, found <= 0, go to DONE.
//      - Miss with k < WIDTH: k <= k + 1, stay in SEARCH.
//    - DONE: out_valid = 1; x and found stay stable. On out_ready go to IDLE and
//      drop out_valid.
//  - First hit wins: the smallest satisfying k is reported.
//  - Latency
//    - Hit at candidate j: out_valid rises j+1 clock edges after the accepting edge.
//    - No solution: out_valid rises WIDTH+1 edges after the accepting edge.
//  - Throughput and back-to-back
//    - No request is accepted in the cycle DONE is left.
//    - in_ready is seen high on the cycle after out_valid & out_ready.
//  - Backpressure: out_ready low holds DONE indefinitely, with x and found frozen.
//  - in_valid during SEARCH or DONE is ignored. The upstream producer must hold the
//    request until in_ready is high.
//  - Output registers: x and found change only on entry to DONE or on reset.
//    In IDLE and SEARCH they keep the last result.
// TESTING (WIDTH = 4 unless stated)
//  - Hit at k=0: s=4'b0110, t=4'b0010, op=00 -> out_valid 1 edge after accept,
//    x=0, found=1.
//  - Signed wrap: s=4'b1000 (-8), t=4'b0001, op=00 -> k=0 misses (-8 > 1 false);
//    x=1, found=1 (4 > 1), out_valid 2 edges after accept.
//  - Unsigned less-than scan: s=4'b1111, t=4'b0010, op=11 -> x=3, found=1,
//    4 edges after accept.
//  - No solution: s=4'b0111, t=4'b0000, op=10 -> found=0, x=0,
//    5 edges (WIDTH+1) after accept.
//  - Backpressure and back-to-back
//    - Hold out_ready=0 for 10 cycles in DONE -> x/found stable, in_ready=0.
//    - Then pulse out_ready -> in_ready=1 on the next cycle.
//    - A second request accepted then completes correctly.
//  - Reset mid-search: s=4'b0000, t=4'b0111, op=00; drop rst_n at k=2 ->
//    next cycle IDLE, out_valid=0, x=0, found=0. A new request then runs from k=0.
//  - Random compare at WIDTH=8 vs a reference model over all (s,t,op) samples.
//    - Check found and minimal x.
//    - Check latency = x+1 edges on a hit and WIDTH+1 edges when not found.

Source files
------------

// File: rtl/bvlshr_inv_search_solver_if.sv
// Handshake/data bundle for bvlshr_inv_search_solver.
//   Request side : in_valid, in_ready, s, t, op
//   Result side  : out_valid, out_ready, x, found
// master = request producer / result consumer, slave = the solver.
interface bvlshr_inv_search_solver_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] t;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic             found;

  modport master (
    output in_valid, s, t, op, out_ready,
    input  in_ready, out_valid, x, found
  );

  modport slave (
    input  in_valid, s, t, op, out_ready,
    output in_ready, out_valid, x, found
  );
endinterface

// File: rtl/bvlshr_inv_search_solver.sv
// Sequential Skolem search for bvlshr: finds the smallest shift amount x in
// 0..WIDTH such that (s >>u x) op t holds, one candidate per clock.
// op: 00 signed >, 01 unsigned >, 10 signed <, 11 unsigned <.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of bvlshr_inv_search_solver_if (valid/ready request
//           carrying s/t/op, valid/ready result carrying x/found)
// x is 0 whenever found is 0. Shifts >= WIDTH all yield 0, so k = WIDTH
// covers the whole tail and the scan is exhaustive.
module bvlshr_inv_search_solver #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  bvlshr_inv_search_solver_if.slave bus
);
  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] t_q;
  logic [1:0]       op_q;
  logic [KW-1:0]    k_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] x_q;
  logic             found_q;

  logic [WIDTH-1:0] r;
  logic             hit;

  // Candidate evaluation for the current k.
  always_comb begin
    r = s_q >> k_q;
    unique case (op_q)
      2'b00:   hit = $signed(r) > $signed(t_q);
      2'b01:   hit = r > t_q;
      2'b10:   hit = $signed(r) < $signed(t_q);
      default: hit = r < t_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      t_q         <= '0;
      op_q        <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      found_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          // Gated by the registered ready so the first cycle after reset
          // (ready still low) cannot accept.
          if (bus.in_valid && in_ready_q) begin
            s_q        <= bus.s;
            t_q        <= bus.t;
            op_q       <= bus.op;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            x_q         <= WIDTH'(k_q);
            found_q     <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (k_q == KW'(WIDTH)) begin
            x_q         <= '0;
            found_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.found     = found_q;
endmodule

// File: tb/tb_bvlshr_inv_search_solver.sv
module tb_bvlshr_inv_search_solver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bvlshr_inv_search_solver_if #(.WIDTH(4)) if4 ();
  bvlshr_inv_search_solver_if #(.WIDTH(8)) if8 ();

  bvlshr_inv_search_solver #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  bvlshr_inv_search_solver #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: try every shift 0..w, interpret values as plain integers,
  // apply the signed view by subtracting 2^w when the top bit is set.
  function automatic int to_signed(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic void ref_solve(input int w, input int s, input int t, input int op,
                                    output int fx, output int ff);
    ff = 0;
    fx = 0;
    for (int k = 0; k <= w; k++) begin
      int r, a, b;
      bit ok;
      r = s >> k;
      a = (op % 2 == 1) ? r : to_signed(r, w);
      b = (op % 2 == 1) ? t : to_signed(t, w);
      ok = (op >= 2) ? (a < b) : (a > b);
      if (ok && ff == 0) begin
        ff = 1;
        fx = k;
      end
    end
  endfunction

  // Issue one request to the 4-bit DUT, check result and latency against
  // hand-computed literals and against the model; hold DONE for 'hold' cycles.
  task automatic run4(input int s, input int t, input int op,
                      input int ex, input int ef, input int elat, input int hold);
    int lat, mx, mf;
    logic [3:0] x0;
    logic f0;
    ref_solve(4, s, t, op, mx, mf);
    chk("model4_x", mx, ex);
    chk("model4_found", mf, ef);
    @(negedge clk);
    chk("w4_in_ready_idle", if4.in_ready, 1);
    if4.in_valid = 1'b1;
    if4.s = 4'(s);
    if4.t = 4'(t);
    if4.op = 2'(op);
    @(posedge clk);
    @(negedge clk);
    if4.in_valid = 1'b0;
    chk("w4_in_ready_busy", if4.in_ready, 0);
    lat = 0;
    while (!if4.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("w4_latency", lat, elat);
    chk("w4_x", if4.x, ex);
    chk("w4_found", if4.found, ef);
    x0 = if4.x;
    f0 = if4.found;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w4_hold_valid", if4.out_valid, 1);
      chk("w4_hold_x", if4.x, x0);
      chk("w4_hold_found", if4.found, f0);
      chk("w4_hold_in_ready", if4.in_ready, 0);
    end
    if4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.out_ready = 1'b0;
    chk("w4_valid_drop", if4.out_valid, 0);
    chk("w4_in_ready_after", if4.in_ready, 1);
    chk("w4_x_kept", if4.x, x0);
  endtask

  task automatic run8(input int s, input int t, input int op, input int hold);
    int lat, mx, mf;
    ref_solve(8, s, t, op, mx, mf);
    @(negedge clk);
    if8.in_valid = 1'b1;
    if8.s = 8'(s);
    if8.t = 8'(t);
    if8.op = 2'(op);
    @(posedge clk);
    @(negedge clk);
    if8.in_valid = 1'b0;
    // Randomly keep in_valid asserted with junk while busy; must be ignored.
    if ($urandom_range(0, 1) == 1) begin
      if8.in_valid = 1'b1;
      if8.s = 8'($urandom);
      if8.t = 8'($urandom);
    end
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if8.in_valid = 1'b0;
    chk("w8_found", if8.found, mf);
    chk("w8_x", if8.x, mx);
    chk("w8_latency", lat, (mf == 1) ? mx + 1 : 9);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w8_hold_x", if8.x, mx);
    end
    if8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.out_ready = 1'b0;
    chk("w8_valid_drop", if8.out_valid, 0);
  endtask

  initial begin
    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.s = '0; if4.t = '0; if4.op = '0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.s = '0; if8.t = '0; if8.op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", if4.in_ready, 0);
    chk("rst_out_valid", if4.out_valid, 0);
    chk("rst_x", if4.x, 0);
    chk("rst_found", if4.found, 0);
    rst_n = 1'b1;
    @(posedge clk);

    // Directed cases at WIDTH = 4.
    run4(4'b0110, 4'b0010, 0, 0, 1, 1, 0);
    run4(4'b1000, 4'b0001, 0, 1, 1, 2, 0);
    run4(4'b1111, 4'b0010, 3, 3, 1, 4, 0);
    run4(4'b0111, 4'b0000, 2, 0, 0, 5, 0);
    // Backpressure for 10 cycles, then an immediate second request.
    run4(4'b1111, 4'b0010, 3, 3, 1, 4, 10);
    run4(4'b1000, 4'b0001, 0, 1, 1, 2, 0);
    run4(4'b1111, 4'b0010, 3, 3, 1, 4, 0);

    // Reset mid-search (no-solution request, abort at k = 2).
    @(negedge clk);
    if4.in_valid = 1'b1;
    if4.s = 4'b0000;
    if4.t = 4'b0111;
    if4.op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    if4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_still_busy", if4.out_valid, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", if4.out_valid, 0);
    chk("mid_rst_x", if4.x, 0);
    chk("mid_rst_found", if4.found, 0);
    chk("mid_rst_in_ready", if4.in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    run4(4'b0110, 4'b0010, 0, 0, 1, 1, 0);
    run4(4'b1000, 4'b0001, 0, 1, 1, 2, 0);

    // Randomized compare at WIDTH = 8.
    for (int i = 0; i < 300; i++) begin
      run8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
           $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
